// File: rtl/pixel_writer_if.sv
// rtl/pixel_writer_if.sv - pixel stream input and memory write bus of pixel_writer
interface pixel_writer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              pix_ready;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    // master is the writer; slave is the upstream source plus memory controller
    modport master (
        input  pix_valid, pix_data, wr_ack,
        output pix_ready, wr_req, wr_addr, wr_data
    );
    modport slave (
        output pix_valid, pix_data, wr_ack,
        input  pix_ready, wr_req, wr_addr, wr_data
    );
endinterface

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - row/column destination address generator and memory write master
// Optional bottom-up row order: PIXEL_WRITER_BOTTOM_UP_EN
module pixel_writer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  num_rows,
    input  logic [CNT_W-1:0]  num_cols,
    input  logic [ADDR_W-1:0] row_stride,
`ifdef PIXEL_WRITER_BOTTOM_UP_EN
    input  logic              bottom_up,
`endif
    pixel_writer_if.master    bus,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W-1:0] PIX_BYTES = ADDR_W'(DATA_W / 8);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_PIX, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]  rows_q, rows_d;
    logic [CNT_W-1:0]  cols_q, cols_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  col_q, col_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  rows_m1;
    logic              last_col, last_row;
    logic [ADDR_W-1:0] first_row_base, next_row_base;

    assign rows_m1  = rows_q - CNT_W'(1);
    assign last_row = (row_q == rows_m1);
    assign last_col = (col_q == cols_q - CNT_W'(1));

`ifdef PIXEL_WRITER_BOTTOM_UP_EN
    logic bu_q, bu_d;
    // Bottom-up starts at the last row and walks the stride backwards
    assign first_row_base = bu_q ? dst_q + ADDR_W'(rows_m1) * stride_q : dst_q;
    assign next_row_base  = bu_q ? row_base_q - stride_q : row_base_q + stride_q;
`else
    assign first_row_base = dst_q;
    assign next_row_base  = row_base_q + stride_q;
`endif

    always_comb begin
        state_d    = state_q;
        dst_d      = dst_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        stride_d   = stride_q;
        row_base_d = row_base_q;
        cur_addr_d = cur_addr_q;
        row_d      = row_q;
        col_d      = col_q;
        wdata_d    = wdata_q;
`ifdef PIXEL_WRITER_BOTTOM_UP_EN
        bu_d       = bu_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    dst_d    = dst_addr;
                    rows_d   = num_rows;
                    cols_d   = num_cols;
                    stride_d = row_stride;
`ifdef PIXEL_WRITER_BOTTOM_UP_EN
                    bu_d     = bottom_up;
`endif
                end
            end
            S_LOAD: begin
                row_base_d = first_row_base;
                cur_addr_d = first_row_base;
                row_d      = '0;
                col_d      = '0;
                state_d    = (rows_q == '0 || cols_q == '0) ? S_DONE : S_WAIT_PIX;
            end
            S_WAIT_PIX: begin
                if (bus.pix_valid) begin
                    wdata_d = bus.pix_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.wr_ack) begin
                    if (last_row && last_col) begin
                        state_d = S_DONE;
                    end else if (last_col) begin
                        col_d      = '0;
                        row_d      = row_q + CNT_W'(1);
                        row_base_d = next_row_base;
                        cur_addr_d = next_row_base;
                        state_d    = S_WAIT_PIX;
                    end else begin
                        col_d      = col_q + CNT_W'(1);
                        cur_addr_d = cur_addr_q + PIX_BYTES;
                        state_d    = S_WAIT_PIX;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dst_q      <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
            stride_q   <= '0;
            row_base_q <= '0;
            cur_addr_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            wdata_q    <= '0;
`ifdef PIXEL_WRITER_BOTTOM_UP_EN
            bu_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dst_q      <= dst_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            stride_q   <= stride_d;
            row_base_q <= row_base_d;
            cur_addr_q <= cur_addr_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wdata_q    <= wdata_d;
`ifdef PIXEL_WRITER_BOTTOM_UP_EN
            bu_q       <= bu_d;
`endif
        end
    end

    // All outputs decode registered state so reset clears them immediately
    assign bus.pix_ready = (state_q == S_WAIT_PIX);
    assign bus.wr_req    = (state_q == S_WRITE);
    assign bus.wr_addr   = cur_addr_q;
    assign bus.wr_data   = wdata_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
endmodule

// File: tb/tb_pixel_writer.sv
// tb/tb_pixel_writer.sv - randomized self-checking bench for pixel_writer
`timescale 1ns/1ps
module tb_pixel_writer;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] dst_addr = '0;
    logic [CNT_W-1:0]  num_rows = '0;
    logic [CNT_W-1:0]  num_cols = '0;
    logic [ADDR_W-1:0] row_stride = '0;
    logic              busy, done;
`ifdef PIXEL_WRITER_BOTTOM_UP_EN
    logic              bottom_up = 1'b0;
`endif

    pixel_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pixel_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .dst_addr(dst_addr),
        .num_rows(num_rows), .num_cols(num_cols), .row_stride(row_stride),
`ifdef PIXEL_WRITER_BOTTOM_UP_EN
        .bottom_up(bottom_up),
`endif
        .bus(bus), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] log_addr[$];
    int exp_done_cyc = -1;
    bit busy_m = 1'b0;
    bit frame_done;
    int done_cyc, first_req_cyc, req_cycles, start_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: frame is a queue of addresses in raster order; data is whatever was handed over
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", {63'd0, busy}, {63'd0, busy_m});
            chk("done", {63'd0, done}, {63'd0, (cyc == exp_done_cyc)});
            if (done) begin
                frame_done = 1'b1;
                done_cyc = cyc;
            end
            if (bus.pix_ready) chk("ready_only_when_busy", {63'd0, busy_m}, 64'd1);
            if (bus.wr_req) begin
                req_cycles++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
                chk("ready_during_write", {63'd0, bus.pix_ready}, 64'd0);
                chk("wr_req_expected", {63'd0, (exp_addr.size() > 0 && exp_data.size() > 0)}, 64'd1);
                if (exp_addr.size() > 0 && exp_data.size() > 0) begin
                    chk("wr_addr", {32'd0, bus.wr_addr}, {32'd0, exp_addr[0]});
                    chk("wr_data", {32'd0, bus.wr_data}, {32'd0, exp_data[0]});
                    if (bus.wr_ack) begin
                        log_addr.push_back(bus.wr_addr);
                        void'(exp_addr.pop_front());
                        void'(exp_data.pop_front());
                        if (exp_addr.size() == 0) exp_done_cyc = cyc + 1;
                    end
                end
            end
            if (bus.pix_ready && bus.pix_valid) exp_data.push_back(bus.pix_data);
            if (cyc == exp_done_cyc) busy_m = 1'b0;
            else if (!busy_m && start) busy_m = 1'b1;
        end
    end

    // amode: 0 immediate ack, 1 ack after 3 waiting cycles, 2 random (also when idle), 3 never
    task automatic run_frame(input logic [31:0] dst, input int rows, input int cols,
                             input logic [31:0] stride, input bit bu, input int amode,
                             input bit vrand, input bit junk, input int budget);
        int t = 0;
        int wcnt = 0;
        @(posedge clk); #1;
        dst_addr = dst;
        num_rows = CNT_W'(rows);
        num_cols = CNT_W'(cols);
        row_stride = stride;
`ifdef PIXEL_WRITER_BOTTOM_UP_EN
        bottom_up = bu;
`endif
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                exp_addr.push_back(dst + 32'(bu ? rows - 1 - r : r) * stride + 32'(c) * 32'd4);
        frame_done = 1'b0;
        first_req_cyc = -1;
        req_cycles = 0;
        log_addr.delete();
        start = 1'b1;
        start_cyc = cyc;
        if (rows == 0 || cols == 0) exp_done_cyc = cyc + 2;
        while (!frame_done && t < budget) begin
            @(posedge clk); #1;
            t++;
            start = junk ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (junk) begin
                dst_addr = $urandom;
                num_rows = CNT_W'($urandom);
                num_cols = CNT_W'($urandom);
                row_stride = $urandom;
            end
            bus.pix_valid = vrand ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.pix_data = $urandom;
            case (amode)
                0: bus.wr_ack = bus.wr_req;
                1: begin
                    wcnt = bus.wr_req ? wcnt + 1 : 0;
                    bus.wr_ack = (wcnt >= 4);
                    if (wcnt >= 4) wcnt = 0;
                end
                2: bus.wr_ack = ($urandom_range(0, 2) == 0);
                default: bus.wr_ack = 1'b0;
            endcase
        end
        start = 1'b0;
        bus.pix_valid = 1'b0;
        bus.wr_ack = 1'b0;
        chk("frame_timeout", {63'd0, frame_done}, 64'd1);
        chk("all_writes_done", 64'(exp_addr.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] seq6[6];
        logic [31:0] seq4[4];
        int t;
        bus.pix_valid = 1'b0;
        bus.pix_data = '0;
        bus.wr_ack = 1'b0;
        #2;
        chk("rst_pix_ready", {63'd0, bus.pix_ready}, 64'd0);
        chk("rst_wr_req", {63'd0, bus.wr_req}, 64'd0);
        chk("rst_wr_addr", {32'd0, bus.wr_addr}, 64'd0);
        chk("rst_wr_data", {32'd0, bus.wr_data}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        #10 rst = 1'b0;

        run_frame(32'd100, 2, 3, 32'd64, 1'b0, 0, 1'b0, 1'b0, 200);
        seq6 = '{32'd100, 32'd104, 32'd108, 32'd164, 32'd168, 32'd172};
        chk("basic_count", 64'(log_addr.size()), 64'd6);
        for (int i = 0; i < 6 && i < log_addr.size(); i++) chk("basic_addr", {32'd0, log_addr[i]}, {32'd0, seq6[i]});
        chk("first_req_latency", 64'(first_req_cyc - start_cyc), 64'd3);
        chk("done_latency", 64'(done_cyc - start_cyc), 64'd14);

        run_frame(32'h40, 3, 0, 32'h10, 1'b0, 0, 1'b0, 1'b0, 50);
        chk("empty_cols_done", 64'(done_cyc - start_cyc), 64'd2);
        chk("empty_cols_reqs", 64'(req_cycles), 64'd0);
        run_frame(32'h80, 0, 5, 32'h10, 1'b0, 0, 1'b0, 1'b0, 50);
        chk("empty_rows_done", 64'(done_cyc - start_cyc), 64'd2);

        run_frame(32'h2000, 3, 4, 32'h80, 1'b0, 1, 1'b1, 1'b0, 2000);
        chk("delayed_wr_cycles", 64'(req_cycles), 64'd48);

        run_frame(32'hFFFF_FFF8, 1, 4, 32'h10, 1'b0, 0, 1'b1, 1'b1, 500);
        seq4 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        chk("wrap_count", 64'(log_addr.size()), 64'd4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) chk("wrap_addr", {32'd0, log_addr[i]}, {32'd0, seq4[i]});

        // Mid-frame reset while a write is pending
        @(posedge clk); #1;
        dst_addr = 32'h300; num_rows = 10'd2; num_cols = 10'd2; row_stride = 32'h40;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) exp_addr.push_back(32'h300 + 32'(r) * 32'h40 + 32'(c) * 4);
        start = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_data = $urandom;
        bus.wr_ack = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (!bus.wr_req && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        chk("reset_test_in_write", {63'd0, bus.wr_req}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_wr_req", {63'd0, bus.wr_req}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_pix_ready", {63'd0, bus.pix_ready}, 64'd0);
        chk("midrst_wr_addr", {32'd0, bus.wr_addr}, 64'd0);
        chk("midrst_wr_data", {32'd0, bus.wr_data}, 64'd0);
        exp_addr.delete();
        exp_data.delete();
        busy_m = 1'b0;
        exp_done_cyc = -1;
        bus.pix_valid = 1'b0;
        #1 rst = 1'b0;
        run_frame(32'h500, 2, 2, 32'h20, 1'b0, 2, 1'b1, 1'b0, 1000);
        chk("after_rst_first_addr", {32'd0, (log_addr.size() > 0 ? log_addr[0] : 32'hDEAD)}, 64'h500);

`ifdef PIXEL_WRITER_BOTTOM_UP_EN
        run_frame(32'h1000, 3, 2, 32'h100, 1'b1, 0, 1'b0, 1'b0, 200);
        seq6 = '{32'h1200, 32'h1204, 32'h1100, 32'h1104, 32'h1000, 32'h1004};
        chk("bu_count", 64'(log_addr.size()), 64'd6);
        for (int i = 0; i < 6 && i < log_addr.size(); i++) chk("bu_addr", {32'd0, log_addr[i]}, {32'd0, seq6[i]});
`endif

        for (int k = 0; k < 10; k++) begin
            bit bu;
`ifdef PIXEL_WRITER_BOTTOM_UP_EN
            bu = 1'($urandom_range(0, 1));
`else
            bu = 1'b0;
`endif
            run_frame($urandom, $urandom_range(1, 4), $urandom_range(1, 5), $urandom, bu,
                      2, 1'b1, 1'($urandom_range(0, 1)), 3000);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1);
    end
endmodule
